// File: rtl/soc_cpu_4_div_cell.sv
// Iterative restoring radix-2 divider for the M-stage: one quotient bit per cycle,
// signed/unsigned operands, start/busy/done handshake with flush abort.
module soc_cpu_4_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    input  logic              M_div_signed,
    input  logic              M_div_start,
    input  logic              M_div_flush,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  count_q;
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic              dz_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] remd_q;

    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W-1:0] src1_abs;
    logic [DATA_W-1:0] src2_abs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    assign src1_neg = M_div_signed & M_div_src1[DATA_W-1];
    assign src2_neg = M_div_signed & M_div_src2[DATA_W-1];
    assign src1_abs = src1_neg ? -M_div_src1 : M_div_src1;
    assign src2_abs = src2_neg ? -M_div_src2 : M_div_src2;

    // The partial remainder is always below the divisor, so DATA_W bits hold it;
    // the shifted value needs one extra bit before the trial subtraction.
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (M_div_flush) begin
                if (state_q != IDLE) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dz_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (M_div_start) begin
                            busy_q     <= 1'b1;
                            dvd_q      <= src1_abs;
                            dvs_q      <= src2_abs;
                            neg_quot_q <= M_div_signed & (M_div_src1[DATA_W-1] ^ M_div_src2[DATA_W-1]);
                            neg_rem_q  <= src1_neg;
                            rem_q      <= '0;
                            count_q    <= '0;
                            if (M_div_src2 == '0) begin
                                quot_q  <= '1;
                                remd_q  <= M_div_src1;
                                dz_q    <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        if (!trial[DATA_W]) begin
                            rem_q <= trial[DATA_W-1:0];
                        end else begin
                            rem_q <= shifted[DATA_W-1:0];
                        end
                        dvd_q   <= {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_LAST) begin
                            state_q <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        quot_q  <= neg_quot_q ? -dvd_q : dvd_q;
                        remd_q  <= neg_rem_q ? -rem_q : rem_q;
                        state_q <= DONE;
                    end
                    DONE: begin
                        // Divide-by-zero drops busy one cycle ahead of its done pulse.
                        busy_q <= 1'b0;
                        if (dz_q) begin
                            dz_q <= 1'b0;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign M_div_busy      = busy_q;
    assign M_div_done      = done_q;
    assign M_div_quotient  = quot_q;
    assign M_div_remainder = remd_q;

endmodule

// File: tb/tb_soc_cpu_4_div_cell.sv
// Directed bench for soc_cpu_4_div_cell: a transaction-level arithmetic model checked
// every cycle, plus hand-computed results and latencies per divide.
module tb_soc_cpu_4_div_cell;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        sgn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] remd;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    soc_cpu_4_div_cell #(.DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .M_div_src1     (src1),
        .M_div_src2     (src2),
        .M_div_signed   (sgn),
        .M_div_start    (start),
        .M_div_flush    (flush),
        .M_div_busy     (busy),
        .M_div_done     (done),
        .M_div_quotient (quot),
        .M_div_remainder(remd)
    );

    // Transaction model: accepted request -> cycles until done plus the arithmetic result.
    bit          m_active = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_dz = 0;
    int          m_left = 0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic [31:0] p_q = '0;
    logic [31:0] p_r = '0;

    always @(posedge clk or negedge reset_n) begin
        longint sa;
        longint sb;
        if (!reset_n) begin
            m_active = 0; m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
            m_q = '0; m_r = '0; p_q = '0; p_r = '0;
        end else begin
            m_done = 0;
            if (m_active) begin
                if (flush) begin
                    m_active = 0;
                    m_busy = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 1) begin
                        m_q = p_q;
                        m_r = p_r;
                        if (m_dz) m_busy = 0;
                    end
                    if (m_left == 0) begin
                        m_active = 0;
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (start && !flush) begin
                m_active = 1;
                m_busy = 1;
                if (src2 == 32'h0) begin
                    m_dz = 1;
                    m_left = 2;
                    p_q = 32'hFFFF_FFFF;
                    p_r = src1;
                    m_q = p_q;
                    m_r = p_r;
                end else begin
                    m_dz = 0;
                    m_left = 34;
                    sa = sgn ? longint'($signed(src1)) : longint'(src1);
                    sb = sgn ? longint'($signed(src2)) : longint'(src2);
                    p_q = 32'(sa / sb);
                    p_r = 32'(sa % sb);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== m_busy || done !== m_done) begin
                errors++;
                $display("FAIL handshake t=%0t busy=%b done=%b required busy=%b done=%b",
                         $time, busy, done, m_busy, m_done);
            end
            if (!m_busy) begin
                checks++;
                if (quot !== m_q || remd !== m_r) begin
                    errors++;
                    $display("FAIL result t=%0t q=%h r=%h required q=%h r=%h",
                             $time, quot, remd, m_q, m_r);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", nm, act, exp);
        end
    endtask

    // Drives one start (sampled at the following edge N); returns just after edge N.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit b2b);
        if (!b2b) @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src1 = ~a; src2 = b ^ 32'h5A5A_0001; sgn = ~s;
    endtask

    // Waits for done with k counting edges after N; checks latency, busy span and results.
    task automatic wait_done(input int elat, input logic [31:0] eq, input logic [31:0] er,
                             input int ebusy, input string nm, input int k0);
        int k = k0;
        int bc = 0;
        while (k < 200 && !done) begin
            if (busy) bc++;
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 32'(k), 32'(elat));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(ebusy));
        chk({nm, "_q"}, quot, eq);
        chk({nm, "_r"}, remd, er);
        $display("div %s: q=%h r=%h done after %0d edges", nm, quot, remd, k);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_q", quot, 32'h0);
        chk("reset_r", remd, 32'h0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        issue(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(34, 32'd14, 32'd2, 34, "u100_7", 0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_done(34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, "s-7_2", 0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        wait_done(34, 32'hFFFF_FFFD, 32'd1, 34, "s7_-2", 0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_done(34, 32'hFFFF_FFFF, 32'd0, 34, "umax_1", 0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done(34, 32'h8000_0000, 32'd0, 34, "smin_-1", 0);
        issue(32'd5, 32'd9, 1'b0, 1'b0);
        wait_done(34, 32'd0, 32'd5, 34, "u5_9", 0);

        issue(32'd1234, 32'd0, 1'b0, 1'b0);
        wait_done(2, 32'hFFFF_FFFF, 32'd1234, 1, "u1234_0", 0);
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
        wait_done(2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, "s-5_0", 0);

        // Second start while busy must be ignored.
        issue(32'd1000, 32'd33, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        src1 = 32'd9; src2 = 32'd3; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(34, 32'd30, 32'd10, 24, "u1000_33_ign", 10);

        // Start in the done cycle is accepted.
        issue(32'd200, 32'd9, 1'b0, 1'b0);
        wait_done(34, 32'd22, 32'd2, 34, "u200_9", 0);
        issue(32'd45, 32'd7, 1'b0, 1'b1);
        wait_done(34, 32'd6, 32'd3, 34, "u45_7_b2b", 0);

        // Flush mid-divide, with a competing start in the same cycle.
        issue(32'd77, 32'd5, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        flush = 1'b1; start = 1'b1; src1 = 32'd9; src2 = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("flush_no_done", 32'(seen), 32'h0);
        chk("flush_q_held", quot, 32'd6);
        chk("flush_r_held", remd, 32'd3);
        $display("div flush: busy=%b q=%h r=%h", busy, quot, remd);

        // Asynchronous reset mid-divide.
        issue(32'd123, 32'd4, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("areset_busy", {31'b0, busy}, 32'h0);
        chk("areset_done", {31'b0, done}, 32'h0);
        chk("areset_q", quot, 32'h0);
        chk("areset_r", remd, 32'h0);
        $display("div reset: busy=%b q=%h r=%h", busy, quot, remd);
        @(negedge clk);
        reset_n = 1'b1;

        issue(32'd50, 32'd5, 1'b0, 1'b0);
        wait_done(34, 32'd10, 32'd0, 34, "u50_5", 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
